kuznechik_arbiter: RTL

- Shares one kuznechik_cipher core between N_REQ independent requesters, using round-robin arbitration.
- Sequences each transaction through the core: launch pulse, wait for completion, capture result, return it tagged with the requester ID.
- Holds a one-entry response buffer. Adds a watchdog so a hung core cannot deadlock the requesters.
- Sits between the requester-facing bus logic and the cipher core at the top level.

---
 rtl/kuznechik_pkg.sv | 24 ++
 rtl/kuznechik_rr_arb.sv | 48 ++++
 rtl/kuznechik_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/kuznechik_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kuznechik_pkg -- shared widths, arbiter state encoding, GOST test vectors
// Revision: 1.0
// ---------------------------------------------------------------------------
package kuznechik_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // GOST R 34.12-2015 reference key, plaintext and ciphertext
  localparam logic [255:0] TV_KEY =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] TV_PT  = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] TV_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;

endpackage
`default_nettype wire

// File: rtl/kuznechik_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kuznechik_rr_arb -- combinational round-robin pick starting after last_grant
// Revision: 1.0
// ---------------------------------------------------------------------------
module kuznechik_rr_arb
  import kuznechik_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] upper_req;
  logic [N_REQ-1:0] pick;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper_mask[i] = (i > int'(last_grant_i));
    end
  end

  // Channels above the pointer take priority; otherwise wrap to the bottom.
  assign upper_req = req_i & upper_mask;
  assign pick      = (|upper_req) ? upper_req : req_i;
  assign any_o     = |req_i;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_o     = '0;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/kuznechik_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kuznechik_arbiter -- shares one cipher core among N_REQ requesters (RR)
// Revision: 1.0
// ---------------------------------------------------------------------------
module kuznechik_arbiter
  import kuznechik_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 512,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*BLOCK_W-1:0] req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         rsp_valid_o,
  input  logic [N_REQ-1:0]         rsp_ready_i,
  output logic [BLOCK_W-1:0]       rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     rsp_err_o,
  output logic                     core_request_o,
  output logic                     core_ack_o,
  output logic [BLOCK_W-1:0]       core_data_o,
  input  logic                     core_busy_i,
  input  logic                     core_valid_i,
  input  logic [BLOCK_W-1:0]       core_data_i,
  output logic                     busy_o
);

  localparam int              WD_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(N_REQ - 1);

  arb_state_e          state_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [WD_W-1:0]     wd_q;
  logic [ID_W-1:0]     owner_q;
  logic [N_REQ-1:0]    owner_oh_q;
  logic [BLOCK_W-1:0]  core_data_q;
  logic [BLOCK_W-1:0]  rsp_data_q;
  logic                rsp_err_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic                core_request_q;
  logic                core_ack_q;

  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic                grant_ok;
  logic [BLOCK_W-1:0]  sel_data;
  logic                owner_ack;

  kuznechik_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arb (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .gnt_idx_o    (arb_idx),
    .any_o        (arb_any)
  );

  // IDLE implies the response buffer is empty, so no separate check is needed.
  assign grant_ok = (state_q == ST_IDLE) && !core_busy_i && arb_any;

  // The grant is combinational, so it is masked while reset is held low.
  assign req_ready_o = (resetn_i && grant_ok) ? arb_gnt : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_data_i[i*BLOCK_W +: BLOCK_W];
      end
    end
  end

  assign owner_ack = |(rsp_ready_i & owner_oh_q);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= LAST_RESET;
      wd_q           <= '0;
      owner_q        <= '0;
      owner_oh_q     <= '0;
      core_data_q    <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_valid_q    <= '0;
      core_request_q <= 1'b0;
      core_ack_q     <= 1'b0;
    end else begin
      core_request_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_ok) begin
            core_data_q    <= sel_data;
            owner_q        <= arb_idx;
            owner_oh_q     <= arb_gnt;
            last_grant_q   <= arb_idx;
            core_request_q <= 1'b1;
            state_q        <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_q       <= '0;
          core_ack_q <= 1'b1;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          // A core result in the timeout cycle still counts as success.
          if (core_valid_i) begin
            rsp_data_q  <= core_data_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= owner_oh_q;
            core_ack_q  <= 1'b0;
            state_q     <= ST_RESP;
          end else if (wd_q == WD_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_oh_q;
            core_ack_q  <= 1'b0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_ack) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_id_o       = owner_q;
  assign rsp_err_o      = rsp_err_q;
  assign core_request_o = core_request_q;
  assign core_ack_o     = core_ack_q;
  assign core_data_o    = core_data_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
